// File: rtl/tetris_input_conditioner_pkg.sv
// Shared types and default timing for the button input conditioner.
// Contents: repeat FSM state enum, 25 MHz timing defaults, small helper.
package tetris_input_conditioner_pkg;

   localparam int unsigned CLK_HZ        = 25_000_000;
   localparam int unsigned N_BTN_DEF     = 4;
   localparam int unsigned DEBOUNCE_10MS = CLK_HZ / 100;
   localparam int unsigned DAS_170MS     = (CLK_HZ / 100) * 17;
   localparam int unsigned ARR_50MS      = CLK_HZ / 20;
   localparam logic [3:0]  REPEAT_MASK_DEF = 4'b0111;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT,
      HELD
   } rep_state_t;

   // Larger of two unsigned values, used to size the shared DAS/ARR timer.
   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/tetris_input_conditioner_if.sv
// Button bus between the raw inputs and the game control path.
// Signals:
//   btn_raw     raw asynchronous button levels, active-high
//   enable      high while the game is running
//   btn_level   debounced button levels
//   btn_press   one-cycle pulse on each debounced 0->1
//   btn_release one-cycle pulse on each debounced 1->0
//   btn_fire    one-cycle move/rotate/drop requests (press + auto-repeat)
// master drives buttons/enable, slave (the conditioner) drives the events.
interface tetris_input_conditioner_if #(
   parameter int unsigned N_BTN = tetris_input_conditioner_pkg::N_BTN_DEF
);

   logic [N_BTN-1:0] btn_raw;
   logic             enable;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;
   logic [N_BTN-1:0] btn_fire;

   modport master (
      output btn_raw, enable,
      input  btn_level, btn_press, btn_release, btn_fire
   );

   modport slave (
      input  btn_raw, enable,
      output btn_level, btn_press, btn_release, btn_fire
   );

endinterface

// File: rtl/tetris_input_conditioner_btn_debounce.sv
// One button channel front end: 2-FF synchroniser, debounce filter and
// registered press/release pulses.
// Ports:
//   clk, reset_n    game clock, synchronous active-low reset
//   raw             asynchronous raw button level
//   level           debounced level
//   press_pulse     high for the first cycle level shows 1
//   release_pulse   high for the first cycle level shows 0
//   level_c         value level takes at the next edge
//   press_c         press_pulse value at the next edge
// DEBOUNCE_CYC must be >= 2.
module tetris_input_conditioner_btn_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic level,
   output logic press_pulse,
   output logic release_pulse,
   output logic level_c,
   output logic press_c
);

   localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             press_q;
   logic             release_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             flip_c;

   // Count consecutive mismatch cycles; flip on the last one, clear otherwise.
   always_comb begin
      flip_c = 1'b0;
      cnt_d  = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            flip_c = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= raw;
         sync2_q   <= sync1_q;
         level_q   <= level_q ^ flip_c;
         press_q   <= flip_c & ~level_q;
         release_q <= flip_c & level_q;
         cnt_q     <= cnt_d;
      end
   end

   assign level         = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign level_c       = level_q ^ flip_c;
   assign press_c       = flip_c & ~level_q;

endmodule

// File: rtl/tetris_input_conditioner.sv
// Turns raw push-buttons into clean game events: per channel a debouncer
// followed by a Tetris-style auto-repeat FSM (DAS delay, then ARR period).
// Ports:
//   clk      25 MHz game clock
//   reset_n  synchronous active-low reset
//   bus      slave side of the button bus (btn_raw, enable in;
//            btn_level, btn_press, btn_release, btn_fire out)
// Parameters: DEBOUNCE_CYC >= 2, DAS_CYC >= 2, ARR_CYC >= 1;
// REPEAT_MASK bit i = 1 lets button i auto-repeat, 0 fires once per press.
module tetris_input_conditioner
   import tetris_input_conditioner_pkg::*;
#(
   parameter int unsigned      N_BTN        = N_BTN_DEF,
   parameter int unsigned      DEBOUNCE_CYC = DEBOUNCE_10MS,
   parameter int unsigned      DAS_CYC      = DAS_170MS,
   parameter int unsigned      ARR_CYC      = ARR_50MS,
   parameter logic [N_BTN-1:0] REPEAT_MASK  = N_BTN'(REPEAT_MASK_DEF)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   tetris_input_conditioner_if.slave   bus
);

   localparam int unsigned      TMR_W    = $clog2(max_u(DAS_CYC, ARR_CYC));
   localparam logic [TMR_W-1:0] DAS_LAST = TMR_W'(DAS_CYC - 1);
   localparam logic [TMR_W-1:0] ARR_LAST = TMR_W'(ARR_CYC - 1);

   logic [N_BTN-1:0] level_v;
   logic [N_BTN-1:0] press_v;
   logic [N_BTN-1:0] release_v;
   logic [N_BTN-1:0] fire_v;
   logic [N_BTN-1:0] level_c_v;
   logic [N_BTN-1:0] press_c_v;

   for (genvar i = 0; i < int'(N_BTN); i++) begin : g_btn

      tetris_input_conditioner_btn_debounce #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_deb (
         .clk           (clk),
         .reset_n       (reset_n),
         .raw           (bus.btn_raw[i]),
         .level         (level_v[i]),
         .press_pulse   (press_v[i]),
         .release_pulse (release_v[i]),
         .level_c       (level_c_v[i]),
         .press_c       (press_c_v[i])
      );

      rep_state_t       state_q;
      rep_state_t       state_d;
      logic [TMR_W-1:0] tmr_q;
      logic [TMR_W-1:0] tmr_d;
      logic             fire_q;
      logic             fire_d;

      // Decisions use the debouncer's next-cycle view so the registered fire
      // lines up with the cycle btn_press shows the new press.
      always_comb begin
         state_d = state_q;
         tmr_d   = tmr_q;
         fire_d  = 1'b0;
         if (!bus.enable || !level_c_v[i]) begin
            // Disabled or released: drop back, and never fire on this cycle.
            state_d = IDLE;
            tmr_d   = '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (press_c_v[i]) begin
                     fire_d  = 1'b1;
                     tmr_d   = '0;
                     state_d = REPEAT_MASK[i] ? DELAY : HELD;
                  end
               end
               DELAY: begin
                  if (tmr_q == DAS_LAST) begin
                     fire_d  = 1'b1;
                     tmr_d   = '0;
                     state_d = REPEAT;
                  end else begin
                     tmr_d = tmr_q + TMR_W'(1);
                  end
               end
               REPEAT: begin
                  if (tmr_q == ARR_LAST) begin
                     fire_d = 1'b1;
                     tmr_d  = '0;
                  end else begin
                     tmr_d = tmr_q + TMR_W'(1);
                  end
               end
               HELD:    state_d = HELD;
               default: state_d = IDLE;
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (!reset_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            fire_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            fire_q  <= fire_d;
         end
      end

      assign fire_v[i] = fire_q;

   end : g_btn

   assign bus.btn_level   = level_v;
   assign bus.btn_press   = press_v;
   assign bus.btn_release = release_v;
   assign bus.btn_fire    = fire_v;

endmodule

// File: tb/tb_tetris_input_conditioner.sv
// Bench for tetris_input_conditioner: directed scenarios plus a random phase,
// scored against a window/arithmetic reference model through an expect queue.
module tb_tetris_input_conditioner;

   localparam int unsigned NB   = 4;
   localparam int unsigned DB   = 4;
   localparam int unsigned DAS  = 10;
   localparam int unsigned ARR  = 3;
   localparam logic [NB-1:0] MASK = 4'b0111;

   typedef int iq_t[$];
   typedef bit bq_t[$];
   typedef struct {
      int            cyc;
      logic [NB-1:0] level;
      logic [NB-1:0] press;
      logic [NB-1:0] rel;
      logic [NB-1:0] fire;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   exp_t exp_q[$];
   iq_t  fire_log[NB];
   iq_t  press_log[NB];
   iq_t  rel_log[NB];

   tetris_input_conditioner_if #(.N_BTN(NB)) bus ();

   tetris_input_conditioner #(
      .N_BTN        (NB),
      .DEBOUNCE_CYC (DB),
      .DAS_CYC      (DAS),
      .ARR_CYC      (ARR),
      .REPEAT_MASK  (MASK)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Edge counter: posedge readers see the previous edge, negedge readers this one.
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: level flips once the last DB synchronised samples all
   // disagree with it; fires at press, press+DAS, press+DAS+k*ARR.
   bq_t hist[NB];
   bit  m_level[NB];
   bit  armed[NB];
   int  t0[NB];

   always @(posedge clk) begin : model
      exp_t e;
      e.cyc   = cyc + 1;
      e.level = '0;
      e.press = '0;
      e.rel   = '0;
      e.fire  = '0;
      for (int b = 0; b < int'(NB); b++) begin
         if (!reset_n) begin
            hist[b].delete();
            for (int j = 0; j < int'(DB) + 2; j++) hist[b].push_back(1'b0);
            m_level[b] = 1'b0;
            armed[b]   = 1'b0;
         end else begin
            bit mism;
            bit rise;
            int d;
            hist[b].push_back(bus.btn_raw[b]);
            if (hist[b].size() > int'(DB) + 2) void'(hist[b].pop_front());
            mism = 1'b1;
            for (int j = 0; j < int'(DB); j++)
               if (hist[b][j] == m_level[b]) mism = 1'b0;
            rise = mism && !m_level[b];
            e.press[b] = rise;
            e.rel[b]   = mism && m_level[b];
            if (mism) m_level[b] = !m_level[b];
            if (!bus.enable || !m_level[b]) begin
               armed[b] = 1'b0;
            end else if (rise) begin
               armed[b]  = 1'b1;
               t0[b]     = e.cyc;
               e.fire[b] = 1'b1;
            end else if (armed[b] && MASK[b]) begin
               d = e.cyc - t0[b];
               e.fire[b] = (d == int'(DAS)) ||
                           (d > int'(DAS) && ((d - int'(DAS)) % int'(ARR)) == 0);
            end
            e.level[b] = m_level[b];
         end
      end
      exp_q.push_back(e);
   end

   // Monitor: compare every presented output cycle against the expect queue.
   always @(negedge clk) begin : monitor
      exp_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL sb_empty: cycle %0d has no expected entry", cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.cyc != cyc || bus.btn_level !== e.level || bus.btn_press !== e.press ||
             bus.btn_release !== e.rel || bus.btn_fire !== e.fire) begin
            n_bad++;
            $display("FAIL sb_cycle_%0d: got lvl=%b prs=%b rel=%b fire=%b, expected (cyc %0d) lvl=%b prs=%b rel=%b fire=%b",
                     cyc, bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_fire,
                     e.cyc, e.level, e.press, e.rel, e.fire);
         end
      end
      for (int b = 0; b < int'(NB); b++) begin
         if (bus.btn_fire[b] === 1'b1)    fire_log[b].push_back(cyc);
         if (bus.btn_press[b] === 1'b1)   press_log[b].push_back(cyc);
         if (bus.btn_release[b] === 1'b1) rel_log[b].push_back(cyc);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      for (int b = 0; b < int'(NB); b++) begin
         fire_log[b].delete();
         press_log[b].delete();
         rel_log[b].delete();
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_q(input string name, input iq_t act, input iq_t exp);
      bit ok;
      n_cmp++;
      ok = (act.size() == exp.size());
      if (ok) foreach (exp[k]) if (act[k] != exp[k]) ok = 1'b0;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: got cycles %p, expected %p", name, act, exp);
      end
   endtask

   int  d, t, r;
   iq_t ex;
   int  lim[NB] = '{5, 11, 29, 29};

   initial begin
      reset_n     = 1'b0;
      bus.btn_raw = '0;
      bus.enable  = 1'b1;
      tick(3);
      check("reset_outputs", int'({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_fire}), 0);
      reset_n = 1'b1;
      tick(2);

      // 1: bounce 1,0,1 then hold; single press 6 cycles after the last edge
      clear_logs();
      bus.btn_raw[0] = 1'b1; tick(2);
      bus.btn_raw[0] = 1'b0; tick(2);
      bus.btn_raw[0] = 1'b1; d = cyc;
      tick(8);
      ex = {d + 6};
      check_q("t1_press", press_log[0], ex);
      check("t1_level", int'(bus.btn_level[0]), 1);

      // 2: held 30 cycles past the rise; DAS then ARR fires; release 6 later
      t = d + 6;
      tick(t + 24 - cyc);
      bus.btn_raw[0] = 1'b0;
      tick(12);
      ex = {t, t + 10, t + 13, t + 16, t + 19, t + 22, t + 25, t + 28};
      check_q("t2_fire", fire_log[0], ex);
      ex = {t + 30};
      check_q("t2_release", rel_log[0], ex);

      // 3: non-repeating button fires once
      clear_logs();
      bus.btn_raw[3] = 1'b1; d = cyc;
      tick(46);
      ex = {d + 6};
      check_q("t3_fire_once", fire_log[3], ex);
      bus.btn_raw[3] = 1'b0;
      tick(10);

      // 4: release during DELAY, re-press restarts DAS
      clear_logs();
      bus.btn_raw[1] = 1'b1; d = cyc; t = d + 6;
      tick(5);
      bus.btn_raw[1] = 1'b0;
      tick(6);
      bus.btn_raw[1] = 1'b1;
      tick(17);
      ex = {t, t + 11, t + 21};
      check_q("t4_fire_restart", fire_log[1], ex);
      bus.btn_raw[1] = 1'b0;
      tick(10);

      // 5: enable low blocks fire; enabling mid-hold does not fire
      clear_logs();
      bus.enable = 1'b0;
      bus.btn_raw[2] = 1'b1; d = cyc;
      tick(10);
      ex = {d + 6};
      check_q("t5_press_disabled", press_log[2], ex);
      check("t5_fire_disabled", fire_log[2].size(), 0);
      bus.enable = 1'b1;
      tick(15);
      check("t5_fire_enable_held", fire_log[2].size(), 0);
      bus.btn_raw[2] = 1'b0;
      tick(10);
      bus.btn_raw[2] = 1'b1; d = cyc;
      tick(8);
      ex = {d + 6};
      check_q("t5_fire_repress", fire_log[2], ex);
      bus.btn_raw[2] = 1'b0;
      tick(10);

      // 6: one-cycle reset mid-REPEAT with button held
      clear_logs();
      bus.btn_raw[0] = 1'b1; d = cyc; t = d + 6;
      tick(19);
      reset_n = 1'b0; r = cyc;
      tick(1);
      check("t6_outputs_in_reset", int'({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_fire}), 0);
      reset_n = 1'b1;
      tick(8);
      ex = {t, t + 10, t + 13, r + 7};
      check_q("t6_fire", fire_log[0], ex);
      ex = {t, r + 7};
      check_q("t6_press", press_log[0], ex);
      bus.btn_raw[0] = 1'b0;
      tick(10);

      // Random phase: per-button toggle rates, occasional enable flips and resets
      repeat (2000) begin
         for (int b = 0; b < int'(NB); b++)
            if ($urandom_range(0, lim[b]) == 0) bus.btn_raw[b] = ~bus.btn_raw[b];
         if ($urandom_range(0, 149) == 0) bus.enable = ~bus.enable;
         reset_n = ($urandom_range(0, 499) != 0);
         tick(1);
      end
      reset_n     = 1'b1;
      bus.enable  = 1'b1;
      bus.btn_raw = '0;
      tick(12);
      check("sb_drain", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
      $fatal(1, "watchdog expired");
   end

endmodule
